// File: rtl/agu_radix_gen.sv
// agu_radix_gen: NTT address generator sweeping j over 2^k beats, emitting R=2^RADIX_LOG bit-reversed butterfly addresses per beat
// Ports: clk/rst (sync, active-high); start, k_in, l_in begin a sweep from IDLE; out_ready is downstream backpressure;
// order/out_valid is the registered beat; l_out is the latched stage index; busy covers RUN and DRAIN; done pulses after the last handshake.
// Optional: define AGU_TWIDDLE_EN to add tw_idx (bit-reversed j), registered alongside order.
module agu_radix_gen #(
  parameter int D_WIDTH = 32,
  parameter int RADIX_LOG = 1,
  parameter int K_MAX = 10,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int R = 1 << RADIX_LOG,
  localparam int JW = (K_MAX > 0) ? K_MAX : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_in,
  input  logic [D_WIDTH-1:0]     l_in,
  input  logic                   out_ready,
  output logic [R*D_WIDTH-1:0]   order,
  output logic                   out_valid,
  output logic [D_WIDTH-1:0]     l_out,
  output logic                   busy,
`ifdef AGU_TWIDDLE_EN
  output logic [D_WIDTH-1:0]     tw_idx,
`endif
  output logic                   done
);
  if (K_MAX + RADIX_LOG > D_WIDTH || RADIX_LOG < 1 || RADIX_LOG > 3) begin : g_bad_cfg
    $error("agu_radix_gen: illegal RADIX_LOG/K_MAX/D_WIDTH combination");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e                 state_q, state_d;
  logic [JW-1:0]          j_q, rev_full, rev;
  logic [KW-1:0]          k_q;
  logic [D_WIDTH-1:0]     l_q;
  logic [R*D_WIDTH-1:0]   order_q, order_d;
  logic                   valid_q, done_q;
  logic                   accept_start, load, last, drain_ack;
`ifdef AGU_TWIDDLE_EN
  logic [D_WIDTH-1:0]     tw_q;
`endif
  for (genvar i = 0; i < JW; i++) begin : g_rev
    assign rev_full[JW-1-i] = j_q[i];
  end
  // Full-width reversal shifted down so only the low k bits of j participate.
  assign rev = rev_full >> (JW - int'(k_q));
  for (genvar m = 0; m < R; m++) begin : g_slot
    assign order_d[m*D_WIDTH +: D_WIDTH] = (D_WIDTH'(rev) << RADIX_LOG) | D_WIDTH'(m);
  end
  assign accept_start = state_q == IDLE && start && !done_q;
  assign load         = state_q == RUN && (!valid_q || out_ready);
  assign last         = j_q == ~({JW{1'b1}} << k_q);
  assign drain_ack    = state_q == DRAIN && out_ready;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = accept_start ? RUN : (load && last) ? DRAIN : drain_ack ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      j_q     <= '0;
      k_q     <= '0;
      l_q     <= '0;
      order_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef AGU_TWIDDLE_EN
      tw_q    <= '0;
`endif
    end else begin
      done_q <= drain_ack;
      if (accept_start) begin
        k_q <= (k_in > KW'(K_MAX)) ? KW'(K_MAX) : k_in;
        l_q <= l_in;
        j_q <= '0;
      end
      if (load) begin
        order_q <= order_d;
        valid_q <= 1'b1;
`ifdef AGU_TWIDDLE_EN
        tw_q    <= D_WIDTH'(rev);
`endif
        if (!last) j_q <= j_q + 1'b1;
      end else if (drain_ack) begin
        valid_q <= 1'b0;
      end
    end
  end
  always_comb begin
    busy      = state_q != IDLE;
    done      = done_q;
    order     = order_q;
    out_valid = valid_q;
    l_out     = l_q;
`ifdef AGU_TWIDDLE_EN
    tw_idx    = tw_q;
`endif
  end
endmodule

// File: tb/tb_agu_radix_gen.sv
// tb_agu_radix_gen: directed table-driven bench for radix-2 and radix-4 instances of agu_radix_gen
module tb_agu_radix_gen;
  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [3:0]   k_in;
  logic [31:0]  l_in;
  logic [63:0]  o1;
  logic [127:0] o2;
  logic         v1, v2, b1, b2, d1, d2;
  logic [31:0]  l1, l2;
`ifdef AGU_TWIDDLE_EN
  logic [31:0]  t1, t2;
`endif
  always #5 clk = ~clk;
  agu_radix_gen #(.D_WIDTH(32), .RADIX_LOG(1), .K_MAX(10)) u1 (
    .clk(clk), .rst(rst), .start(start), .k_in(k_in), .l_in(l_in), .out_ready(out_ready),
    .order(o1), .out_valid(v1), .l_out(l1), .busy(b1),
`ifdef AGU_TWIDDLE_EN
    .tw_idx(t1),
`endif
    .done(d1));
  agu_radix_gen #(.D_WIDTH(32), .RADIX_LOG(2), .K_MAX(10)) u2 (
    .clk(clk), .rst(rst), .start(start), .k_in(k_in), .l_in(l_in), .out_ready(out_ready),
    .order(o2), .out_valid(v2), .l_out(l2), .busy(b2),
`ifdef AGU_TWIDDLE_EN
    .tw_idx(t2),
`endif
    .done(d2));
  typedef struct {int k; int beat; int b1; int b2; int tw;} vec_t;
  vec_t v[13];
  int n_chk = 0, n_fail = 0;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] ex1(int b);
    return {32'(b + 1), 32'(b)};
  endfunction
  function automatic logic [127:0] ex2(int b);
    return {32'(b + 3), 32'(b + 2), 32'(b + 1), 32'(b)};
  endfunction
  task automatic go(int k, int l);
    start = 1'b1;
    k_in  = 4'(k);
    l_in  = 32'(l);
    tick;
    start = 1'b0;
  endtask
  task automatic wait_valid(string nm);
    int n = 0;
    while (!v1 && n < 20) begin
      tick;
      n++;
    end
    chk(nm, 128'(v1), 128'(1));
  endtask
  initial begin
    int exp3[8] = '{0, 8, 4, 12, 2, 10, 6, 14};
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    int hs, dn, cnt;
    bit stalled, is_last;
    logic [63:0] held;
    v[0]  = '{3, 0, 0, 0, 0};   v[1]  = '{3, 1, 8, 16, 4};
    v[2]  = '{3, 2, 4, 8, 2};   v[3]  = '{3, 3, 12, 24, 6};
    v[4]  = '{3, 4, 2, 4, 1};   v[5]  = '{3, 5, 10, 20, 5};
    v[6]  = '{3, 6, 6, 12, 3};  v[7]  = '{3, 7, 14, 28, 7};
    v[8]  = '{2, 0, 0, 0, 0};   v[9]  = '{2, 1, 4, 8, 2};
    v[10] = '{2, 2, 2, 4, 1};   v[11] = '{2, 3, 6, 12, 3};
    v[12] = '{0, 0, 0, 0, 0};
    rst = 1'b1; start = 1'b0; k_in = '0; l_in = '0; out_ready = 1'b1;
    tick;
    tick;
    chk("reset order1", 128'(o1), 128'(0));
    chk("reset order2", o2, 128'(0));
    chk("reset valid", 128'(v1), 128'(0));
    chk("reset busy", 128'(b1), 128'(0));
    chk("reset done", 128'(d1), 128'(0));
    chk("reset l_out", 128'(l1), 128'(0));
`ifdef AGU_TWIDDLE_EN
    chk("reset tw", 128'(t1), 128'(0));
`endif
    rst = 1'b0;
    tick;
    for (int i = 0; i < 13; i++) begin
      if (v[i].beat == 0) begin
        go(v[i].k, 100 + v[i].k);
        wait_valid($sformatf("first valid k%0d", v[i].k));
      end else begin
        chk($sformatf("valid k%0d b%0d", v[i].k, v[i].beat), 128'(v1), 128'(1));
      end
      chk($sformatf("order r2 k%0d b%0d", v[i].k, v[i].beat), 128'(o1), 128'(ex1(v[i].b1)));
      chk($sformatf("order r4 k%0d b%0d", v[i].k, v[i].beat), o2, ex2(v[i].b2));
`ifdef AGU_TWIDDLE_EN
      chk($sformatf("tw r2 k%0d b%0d", v[i].k, v[i].beat), 128'(t1), 128'(v[i].tw));
      chk($sformatf("tw r4 k%0d b%0d", v[i].k, v[i].beat), 128'(t2), 128'(v[i].tw));
`endif
      chk($sformatf("l_out k%0d", v[i].k), 128'(l1), 128'(100 + v[i].k));
      chk($sformatf("busy k%0d b%0d", v[i].k, v[i].beat), 128'(b1), 128'(1));
      tick;
      is_last = (i == 12) ? 1'b1 : (v[i + 1].beat == 0);
      if (is_last) begin
        chk($sformatf("done k%0d", v[i].k), 128'(d1), 128'(1));
        chk($sformatf("busy low k%0d", v[i].k), 128'(b1), 128'(0));
        chk($sformatf("valid low k%0d", v[i].k), 128'(v1), 128'(0));
        tick;
        chk($sformatf("done pulse k%0d", v[i].k), 128'(d1), 128'(0));
      end
    end
    go(3, 77);
    l_in = 32'd999;
    k_in = 4'd0;
    hs = 0; dn = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 60; c++) begin
      out_ready = pat[c % 6];
      start = (c == 5) || d1;
      if (stalled) chk($sformatf("stall hold c%0d", c), 128'(o1), 128'(held));
      if (v1 && out_ready) begin
        if (hs < 8) chk($sformatf("stall order hs%0d", hs), 128'(o1), 128'(ex1(exp3[hs])));
        hs++;
      end
      stalled = v1 && !out_ready;
      held = o1;
      dn += int'(d1);
      tick;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("stall handshakes", 128'(hs), 128'(8));
    chk("stall done count", 128'(dn), 128'(1));
    chk("l_out kept", 128'(l1), 128'(77));
    chk("ignored start busy", 128'(b1), 128'(0));
    go(15, 5);
    cnt = 0;
    for (int c = 0; c < 1100 && !d1; c++) begin
      if (v1 && out_ready) cnt++;
      tick;
    end
    chk("k sat beats", 128'(cnt), 128'(1024));
    chk("k sat done", 128'(d1), 128'(1));
    tick;
    go(3, 1);
    wait_valid("rst test valid");
    tick;
    tick;
    tick;
    chk("rst beat3 order", 128'(o1), 128'(ex1(12)));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst valid", 128'(v1), 128'(0));
    chk("rst busy", 128'(b1), 128'(0));
    chk("rst done", 128'(d1), 128'(0));
    tick;
    chk("rst no done", 128'(d1), 128'(0));
    go(3, 2);
    wait_valid("restart valid");
    chk("restart beat0", 128'(o1), 128'(ex1(0)));
    tick;
    chk("restart beat1", 128'(o1), 128'(ex1(8)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/agu_radix_gen.md
# agu_radix_gen

Parametrised NTT address-generation unit that succeeds the fixed last-stage radix-2 AGU. On `start` it sweeps a block counter `j` over `2^k` iterations, bit-reverses `j` over `k` bits, and emits `R = 2^RADIX_LOG` butterfly operand addresses per beat. It uses a valid/ready output handshake with full backpressure. It sits between the NTT stage controller and the memory-bank address crossbar.

## Interface
- `D_WIDTH`, 32: width of every address/index output.
- `RADIX_LOG`, 1: log2 of the radix. `R = 2^RADIX_LOG` addresses are emitted per beat. Legal range 1..3.
- `K_MAX`, 10: maximum supported `k`. Elaboration fails unless `K_MAX + RADIX_LOG <= D_WIDTH`.
- `clk`  in  1  clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request a sweep. Sampled only in IDLE.
- `k_in`  in  $clog2(K_MAX+1)  bit-reversal width. Latched on accepted `start`.
- `l_in`  in  D_WIDTH  stage index. Latched on accepted `start`.
- `out_ready`  in  1  downstream accepts the current beat.
- `order`  out  R*D_WIDTH  flattened addresses. Slot `m` occupies bits `[m*D_WIDTH +: D_WIDTH]`.
- `out_valid`  out  1  `order` (and `tw_idx`, when compiled in) is valid.
- `l_out`  out  D_WIDTH  latched stage index. Holds until the next accepted `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  single-cycle pulse after the final beat is accepted.

## Operation
- FSM states:
  - IDLE: `start` moves to RUN. It latches `k = min(k_in, K_MAX)`, latches `l_in`, and sets `j = 0`.
  - RUN: loads beat `j` into the output register. It advances `j` whenever the output register is empty or being accepted this cycle.
  - DRAIN: the last beat has been loaded and is waiting for `out_ready`.
  - DRAIN exit: on acceptance of the last beat, return to IDLE and pulse `done` the following cycle.
- Beat `j` runs from 0 to `2^k - 1` inclusive, giving exactly `2^k` beats. There is no extra beat at `j = 2^k`.
- `rev = bitrev_k(j)`: bit `i` of `j` maps to bit `k-1-i`, for `i < k`. When `k = 0`, `rev = 0`.
- `order[m] = (rev << RADIX_LOG) + m`, for `m = 0..R-1`.
  - Results are zero-extended to D_WIDTH.
  - There is no overflow, guaranteed by the elaboration check.
- Output register: `order`, `out_valid` and `tw_idx` form a one-entry skid-free stage.
  - While `out_valid && !out_ready`, all outputs hold stable.
  - `j` does not advance during this hold.
- `start` is ignored while `busy`. It is also ignored in the cycle `done` is high.
- `k_in = 0` produces one beat, with `order[m] = m`.
- `k_in > K_MAX` saturates to `K_MAX`.

## Timing
- Reset values: `order = 0`, `out_valid = 0`, `busy = 0`, `done = 0`, `l_out = 0`, `tw_idx = 0`. Internal `j = 0`, `k = 0`, state IDLE.
- Latency: `start` accepted at edge N makes `out_valid = 1` with beat 0 after edge N+1.
- Throughput: 1 beat/cycle while `out_ready` is held high. A sweep of `2^k` beats therefore occupies `2^k + 1` cycles from `start` to the last acceptance.
- `done` is asserted in the cycle after the last handshake (`out_valid && out_ready`). It is high for exactly one cycle. `busy` falls in that same cycle.
- `rst` asserted in any state forces reset values at the next edge. Any in-flight beat is discarded and `done` is not generated.
- `out_ready` is allowed to toggle arbitrarily. No beat may be dropped or duplicated.

## Configuration
- `AGU_TWIDDLE_EN` defined:
  - Adds output `tw_idx  out  D_WIDTH`, equal to `rev` zero-extended.
  - It is registered alongside `order` and obeys the same hold rule. The twiddle ROM is addressed directly from it.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- RADIX_LOG=1, k_in=3, `out_ready = 1`:
  - `order[0]` must be 0,8,4,12,2,10,6,14 and `order[1]` must be `order[0] + 1`.
  - `out_valid` is high for 8 consecutive cycles. `done` pulses once on the cycle after the 8th beat.
- RADIX_LOG=2, k_in=2:
  - Base addresses must be 0,8,4,12.
  - Beat 1 must be `order = {11,10,9,8}` (slot 3..0).
  - With `AGU_TWIDDLE_EN`, `tw_idx` must be 0,2,1,3.
- k_in=3 with `out_ready` pattern 1,0,0,1,0,1,...:
  - The accepted sequence must equal the unstalled sequence.
  - `order` must be stable during every stall.
  - Exactly 8 handshakes, then `done`.
- k_in=0, then k_in=15 with K_MAX=10:
  - First case: a single beat with `order[m] = m`.
  - Second case: exactly 1024 beats.
- `start` pulsed mid-sweep and again on the `done` cycle: both are ignored. `l_out` retains the first latched `l_in`.
- `rst` asserted at beat 3 of a k=3 sweep:
  - Next cycle `out_valid = 0` and `busy = 0`, with no `done`.
  - A fresh `start` restarts from `order[0] = 0`.
